// File: rtl/com_pkg.sv
// Shared types and width helpers for the multi-target centre-of-mass tracker.
package com_pkg;

    typedef enum logic [2:0] {IDLE, SCAN, DIVX, DIVY, PUBLISH} com_state_e;

    localparam int unsigned DEF_H_WIDTH    = 11;
    localparam int unsigned DEF_V_WIDTH    = 10;
    localparam int unsigned DEF_CNT_WIDTH  = 20;
    localparam int unsigned DEF_MIN_PIXELS = 16;

    function automatic int unsigned sum_width(input int unsigned coord_w,
                                              input int unsigned cnt_w);
        return coord_w + cnt_w;
    endfunction

    // Divider width covers the wider of the two coordinate sums.
    function automatic int unsigned div_width(input int unsigned h_w, input int unsigned v_w,
                                              input int unsigned cnt_w);
        return ((h_w > v_w) ? h_w : v_w) + cnt_w;
    endfunction

    localparam int unsigned DEF_DW = div_width(DEF_H_WIDTH, DEF_V_WIDTH, DEF_CNT_WIDTH);

endpackage

// File: rtl/com_divider.sv
// Unsigned restoring radix-2 divider; one quotient bit per cycle, WIDTH cycles per divide.
module com_divider #(
    parameter int unsigned WIDTH = 31
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] src_rem, src_quo, src_dsr, rem_nx, quo_nx;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // The first quotient bit is produced in the start cycle itself.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dsr = start ? divisor : dsr_q;
        shifted = {src_rem, src_quo[WIDTH-1]};
        ge      = shifted >= {1'b0, src_dsr};
        rem_nx  = ge ? (shifted[WIDTH-1:0] - src_dsr) : shifted[WIDTH-1:0];
        quo_nx  = {src_quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            dsr_q <= divisor;
            cnt_q <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/multi_target_com.sv
// Per-frame centroid and presence tracker for NUM_TARGETS mask channels,
// sharing one sequential divider across all targets.
module multi_target_com
    import com_pkg::*;
#(
    parameter int unsigned NUM_TARGETS = 4,
    parameter int unsigned H_WIDTH     = DEF_H_WIDTH,
    parameter int unsigned V_WIDTH     = DEF_V_WIDTH,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int unsigned MIN_PIXELS  = DEF_MIN_PIXELS
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [H_WIDTH-1:0]             x_in,
    input  logic [V_WIDTH-1:0]             y_in,
    input  logic [NUM_TARGETS-1:0]         valid_in,
    input  logic                           tabulate_in,
    output logic [NUM_TARGETS*H_WIDTH-1:0] x_out,
    output logic [NUM_TARGETS*V_WIDTH-1:0] y_out,
    output logic [NUM_TARGETS-1:0]         present_out,
    output logic                           valid_out,
    output logic                           busy_out,
    output logic                           drop_out
);
    localparam int unsigned SXW = sum_width(H_WIDTH, CNT_WIDTH);
    localparam int unsigned SYW = sum_width(V_WIDTH, CNT_WIDTH);
    localparam int unsigned DW  = div_width(H_WIDTH, V_WIDTH, CNT_WIDTH);
    localparam int unsigned KW  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam logic [KW-1:0]        K_LAST  = KW'(NUM_TARGETS - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_PIXELS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SXW-1:0]       sum_x_q [NUM_TARGETS];
    logic [SYW-1:0]       sum_y_q [NUM_TARGETS];
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_TARGETS];
    logic [SXW-1:0]       sum_x_nx[NUM_TARGETS];
    logic [SYW-1:0]       sum_y_nx[NUM_TARGETS];
    logic [CNT_WIDTH-1:0] cnt_nx  [NUM_TARGETS];
    logic [SXW-1:0]       sh_x_q  [NUM_TARGETS];
    logic [SYW-1:0]       sh_y_q  [NUM_TARGETS];
    logic [CNT_WIDTH-1:0] sh_cnt_q[NUM_TARGETS];
    logic [H_WIDTH-1:0]   res_x_q [NUM_TARGETS];
    logic [V_WIDTH-1:0]   res_y_q [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] res_p_q;

    com_state_e     state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic           meets;
    logic           div_start, div_done, div_busy;
    logic [DW-1:0]  div_dividend, div_divisor, div_quo;
    logic           unused_quo;

    always_comb begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
            sum_x_nx[i] = sum_x_q[i] + (valid_in[i] ? SXW'(x_in) : '0);
            sum_y_nx[i] = sum_y_q[i] + (valid_in[i] ? SYW'(y_in) : '0);
            cnt_nx[i]   = (valid_in[i] && cnt_q[i] != CNT_MAX) ? cnt_q[i] + CNT_WIDTH'(1)
                                                               : cnt_q[i];
        end
    end

    // The tabulate-cycle pixel is folded into the snapshot, never into the next frame.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                sum_x_q[i]  <= '0;
                sum_y_q[i]  <= '0;
                cnt_q[i]    <= '0;
                sh_x_q[i]   <= '0;
                sh_y_q[i]   <= '0;
                sh_cnt_q[i] <= '0;
            end
            drop_out <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                sum_x_q[i] <= tabulate_in ? '0 : sum_x_nx[i];
                sum_y_q[i] <= tabulate_in ? '0 : sum_y_nx[i];
                cnt_q[i]   <= tabulate_in ? '0 : cnt_nx[i];
                if (tabulate_in && state_q == IDLE) begin
                    sh_x_q[i]   <= sum_x_nx[i];
                    sh_y_q[i]   <= sum_y_nx[i];
                    sh_cnt_q[i] <= cnt_nx[i];
                end
            end
            drop_out <= tabulate_in && (state_q != IDLE);
        end
    end

    always_comb begin
        meets        = sh_cnt_q[k_q] >= MIN_CNT;
        div_dividend = (state_q == DIVY) ? DW'(sh_y_q[k_q]) : DW'(sh_x_q[k_q]);
        div_divisor  = DW'(sh_cnt_q[k_q]);
    end

    com_divider #(
        .WIDTH(DW)
    ) u_div (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .quotient(div_quo),
        .done    (div_done),
        .busy    (div_busy)
    );

    assign unused_quo = ^div_quo;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (tabulate_in) begin
                    state_d = SCAN;
                    k_d     = '0;
                end
            end
            SCAN: begin
                if (meets) begin
                    state_d = DIVX;
                end else if (k_q == K_LAST) begin
                    state_d = PUBLISH;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DIVX: begin
                div_start = !div_busy && !div_done;
                if (div_done) state_d = DIVY;
            end
            DIVY: begin
                div_start = !div_busy && !div_done;
                if (div_done) begin
                    if (k_q == K_LAST) begin
                        state_d = PUBLISH;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = SCAN;
                    end
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Absent targets keep their last centroid; only the present bit is rewritten.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                res_x_q[i] <= '0;
                res_y_q[i] <= '0;
            end
            res_p_q     <= '0;
            x_out       <= '0;
            y_out       <= '0;
            present_out <= '0;
            valid_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state_q)
                SCAN: res_p_q[k_q] <= meets;
                DIVX: if (div_done) res_x_q[k_q] <= div_quo[H_WIDTH-1:0];
                DIVY: if (div_done) res_y_q[k_q] <= div_quo[V_WIDTH-1:0];
                PUBLISH: begin
                    for (int i = 0; i < NUM_TARGETS; i++) begin
                        x_out[i*H_WIDTH +: H_WIDTH] <= res_x_q[i];
                        y_out[i*V_WIDTH +: V_WIDTH] <= res_y_q[i];
                    end
                    present_out <= res_p_q;
                    valid_out   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_multi_target_com.sv
// Directed bench for multi_target_com: a pixel-level model predicts each published frame.
module tb_multi_target_com;
    localparam int NT  = 4;
    localparam int HW  = 11;
    localparam int VW  = 10;
    localparam int DWB = 32;  // divider latency + 1 at default widths

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [HW-1:0]     x_in = '0;
    logic [VW-1:0]     y_in = '0;
    logic [NT-1:0]     valid_in = '0;
    logic              tabulate_in = 1'b0;
    logic [NT*HW-1:0]  x_out;
    logic [NT*VW-1:0]  y_out;
    logic [NT-1:0]     present_out;
    logic              valid_out, busy_out, drop_out;

    always #5 clk = ~clk;

    multi_target_com dut (
        .clk_in     (clk),
        .rst_in     (rst_n),
        .x_in       (x_in),
        .y_in       (y_in),
        .valid_in   (valid_in),
        .tabulate_in(tabulate_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .present_out(present_out),
        .valid_out  (valid_out),
        .busy_out   (busy_out),
        .drop_out   (drop_out)
    );

    typedef struct {
        logic [NT*HW-1:0] x;
        logic [NT*VW-1:0] y;
        logic [NT-1:0]    p;
        int               lat;
    } exp_t;

    exp_t    sb[$];
    int      n_total = 0, n_pass = 0;
    int      cyc = 0, valid_seen = 0, drop_seen = 0, tab_cyc = 0;
    longint  msx[NT], msy[NT];
    int      mcnt[NT], prev_x[NT], prev_y[NT];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (valid_out) valid_seen <= valid_seen + 1;
        if (drop_out) drop_seen <= drop_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NT; i++) begin
            msx[i] = 0;
            msy[i] = 0;
            mcnt[i] = 0;
        end
    endtask

    task automatic model_add(input logic [NT-1:0] v, input int x, input int y);
        for (int i = 0; i < NT; i++) begin
            if (v[i]) begin
                msx[i] += x;
                msy[i] += y;
                mcnt[i]++;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        int   np = 0;
        e.p = '0;
        for (int i = 0; i < NT; i++) begin
            if (mcnt[i] >= 16) begin
                prev_x[i] = int'(msx[i] / mcnt[i]);
                prev_y[i] = int'(msy[i] / mcnt[i]);
                e.p[i] = 1'b1;
                np++;
            end
            e.x[i*HW +: HW] = HW'(prev_x[i]);
            e.y[i*VW +: VW] = VW'(prev_y[i]);
        end
        e.lat = 1 + NT + 2 * DWB * np + 1;
        sb.push_back(e);
    endtask

    task automatic pix(input logic [NT-1:0] v, input int x, input int y);
        x_in = HW'(x);
        y_in = VW'(y);
        valid_in = v;
        model_add(v, x, y);
        tick();
        valid_in = '0;
    endtask

    // Frame-end pulse carrying an optional final pixel; a dropped frame only clears.
    task automatic tab(input logic [NT-1:0] v, input int x, input int y, input bit drop);
        x_in = HW'(x);
        y_in = VW'(y);
        valid_in = v;
        tabulate_in = 1'b1;
        model_add(v, x, y);
        if (!drop) push_expected();
        model_clear();
        tick();
        tabulate_in = 1'b0;
        valid_in = '0;
        if (!drop) tab_cyc = cyc;
    endtask

    task automatic wait_publish(input string tag);
        exp_t e;
        int   n = 0;
        while (valid_out !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        if (valid_out !== 1'b1) begin
            chk({tag, "_timeout"}, 64'(valid_out), 64'd1);
            return;
        end
        chk({tag, "_latency"}, 64'(cyc - tab_cyc + 1), 64'(e.lat));
        chk({tag, "_x"}, 64'(x_out), 64'(e.x));
        chk({tag, "_y"}, 64'(y_out), 64'(e.y));
        chk({tag, "_present"}, 64'(present_out), 64'(e.p));
        tick();
        chk({tag, "_valid_one_cycle"}, 64'(valid_out), 64'd0);
        chk({tag, "_idle_after"}, 64'(busy_out), 64'd0);
    endtask

    initial begin
        int v0;
        model_clear();
        for (int i = 0; i < NT; i++) begin
            prev_x[i] = 0;
            prev_y[i] = 0;
        end
        #12;
        chk("rst_x", 64'(x_out), 64'd0);
        chk("rst_y", 64'(y_out), 64'd0);
        chk("rst_flags", 64'({present_out, valid_out, busy_out, drop_out}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Two-point centroid; the 16th pixel rides on the tabulate cycle
        for (int i = 0; i < 8; i++) pix(4'b0001, 100, 50);
        for (int i = 0; i < 7; i++) pix(4'b0001, 102, 54);
        tab(4'b0001, 102, 54, 1'b0);
        chk("t1_busy", 64'(busy_out), 64'd1);
        wait_publish("t1");

        // T0 one short of threshold, T2 exactly at it
        for (int i = 0; i < 15; i++) pix(4'b0001, 10, 10);
        for (int i = 0; i < 15; i++) pix(4'b0100, 640, 360);
        tab(4'b0100, 640, 360, 1'b0);
        wait_publish("t2");

        // Truncating quotients: 1001/16 and 999/16
        for (int i = 0; i < 15; i++) pix(4'b0010, 62, 62);
        tab(4'b0010, 71, 69, 1'b0);
        wait_publish("t3");

        // Frame end arriving mid-pass is dropped and its pixels discarded
        for (int i = 0; i < 16; i++) pix(4'b0001, 200, 100);
        tab(4'b0000, 0, 0, 1'b0);
        for (int i = 0; i < 9; i++) pix(4'b0001, 900, 600);
        tab(4'b0000, 0, 0, 1'b1);
        chk("t4_drop_pulse", 64'(drop_out), 64'd1);
        chk("t4_still_busy", 64'(busy_out), 64'd1);
        wait_publish("t4a");
        for (int i = 0; i < 16; i++) pix(4'b0001, 400, 300);
        tab(4'b0000, 0, 0, 1'b0);
        wait_publish("t4b");

        // All targets over frame-symmetric pixels: mean (639.5, 359.5), worst-case latency
        for (int j = 0; j < 32; j++) begin
            pix(4'b1111, j * 20, j * 11);
            pix(4'b1111, 1279 - j * 20, 719 - j * 11);
        end
        tab(4'b0000, 0, 0, 1'b0);
        wait_publish("t5");

        // Reset while the y divide of target 0 is running
        for (int i = 0; i < 16; i++) pix(4'b0001, 300, 200);
        tab(4'b0000, 0, 0, 1'b0);
        repeat (39) tick();
        chk("t6_busy_before_rst", 64'(busy_out), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_x", 64'(x_out), 64'd0);
        chk("t6_rst_y", 64'(y_out), 64'd0);
        chk("t6_rst_flags", 64'({present_out, valid_out, busy_out, drop_out}), 64'd0);
        tick();
        rst_n = 1'b1;
        sb.delete();
        model_clear();
        for (int i = 0; i < NT; i++) begin
            prev_x[i] = 0;
            prev_y[i] = 0;
        end
        v0 = valid_seen;
        repeat (300) tick();
        chk("t6_no_valid", 64'(valid_seen), 64'(v0));
        for (int i = 0; i < 16; i++) pix(4'b0001, 1000, 700);
        for (int i = 0; i < 15; i++) pix(4'b1000, 5, 7);
        tab(4'b1000, 5, 7, 1'b0);
        wait_publish("t6");

        chk("drop_count", 64'(drop_seen), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_target_com.md
# multi_target_com

- Per-frame centroid and presence tracker for up to NUM_TARGETS independent colour masks; successor to the single-target centre-of-mass block.
- Sits in the clk_pixel domain after the per-target thresholders. Consumes pipelined hcount/vcount plus one mask bit per target.
- At each frame end it snapshots its accumulators and computes every target's centroid with one shared sequential divider. It then publishes all results together in a single valid_out pulse.

## Interface
Parameters:
- NUM_TARGETS, 4: number of independent mask channels (1–8)
- H_WIDTH, 11: width of x_in / x coordinates
- V_WIDTH, 10: width of y_in / y coordinates
- CNT_WIDTH, 20: pixel-count width; count saturates at 2^CNT_WIDTH−1
- MIN_PIXELS, 16: minimum count for a target to be "present" (must be ≥1)

Ports:
- clk_in  in  1  pixel clock (clk_pixel)
- rst_in  in  1  reset: asynchronous, active-low
- x_in  in  H_WIDTH  pixel x coordinate
- y_in  in  V_WIDTH  pixel y coordinate
- valid_in  in  NUM_TARGETS  per-target mask bit for the current pixel
- tabulate_in  in  1  single-cycle frame-end pulse
- x_out  out  NUM_TARGETS*H_WIDTH  packed centroids; target i at [i*H_WIDTH +: H_WIDTH]
- y_out  out  NUM_TARGETS*V_WIDTH  packed centroids, same packing
- present_out  out  NUM_TARGETS  target met MIN_PIXELS in the last published frame
- valid_out  out  1  one-cycle pulse when all outputs are updated
- busy_out  out  1  high while a division pass is running
- drop_out  out  1  one-cycle pulse when a frame snapshot is discarded

## Operation
- **Accumulation** (always running): on each cycle, for every target i with valid_in[i]=1:
  - sum_x[i] += x_in
  - sum_y[i] += y_in
  - cnt[i] += 1, saturating
- **Sum widths:** sum widths are H_WIDTH+CNT_WIDTH and V_WIDTH+CNT_WIDTH. Sums do not saturate; they cannot overflow while cnt is unsaturated.
- **tabulate_in in IDLE:**
  - Copy sum_x, sum_y and cnt of every target into shadow registers.
  - Clear the accumulators in the same cycle.
  - A pixel presented in the tabulate_in cycle belongs to the ending frame and is included in the snapshot.
- **State machine:** IDLE → SCAN → DIVX → DIVY → SCAN … → PUBLISH → IDLE.
  - SCAN examines target index k, starting at 0.
  - If shadow cnt[k] ≥ MIN_PIXELS: mark present, go to DIVX.
  - Otherwise: mark absent and advance k. When k wraps past NUM_TARGETS−1, go to PUBLISH.
  - DIVX computes sum_x/cnt; DIVY computes sum_y/cnt. Each starts the divider and waits for its done.
  - Quotients are truncated (floor) and the low H_WIDTH / V_WIDTH bits are kept. After DIVY, advance k and return to SCAN.
  - PUBLISH copies result registers to x_out, y_out and present_out, pulses valid_out, and returns to IDLE.
- **Absent targets:** their x_out/y_out hold the previous published value; only present_out clears.
- **tabulate_in outside IDLE:**
  - Accumulators are still cleared, so the frame's data is lost.
  - drop_out pulses and the in-progress pass continues unaffected.
- **Divide by zero** is impossible, since the divider only starts when cnt ≥ MIN_PIXELS ≥ 1.

## Timing
- Reset (rst_in=0, asynchronous): all outputs and all internal state go to 0, and the state machine goes to IDLE.
  - Reset mid-pass abandons the pass with no valid_out.
- Divider: restoring radix-2, one quotient bit per cycle, latency DW = H_WIDTH+CNT_WIDTH cycles. The x and y divides share it.
- Pass latency from tabulate_in:
  - 1 cycle (snapshot)
  - + 1 cycle per SCAN visit
  - + 2·(DW+1) cycles per present target
  - + 1 cycle (PUBLISH)
  - Worst case at defaults: 1+4+4·64+1 = 262 cycles. This is far below one line, so drops never occur in normal video.
- valid_out is asserted exactly one cycle. x_out, y_out and present_out change only in that cycle.
- busy_out is high from the cycle after tabulate_in through PUBLISH inclusive.

## Structure
- Package com_pkg holds:
  - state enum {IDLE, SCAN, DIVX, DIVY, PUBLISH}
  - width-derivation localparams (sum widths, DW)
  - a MIN_PIXELS default constant
- Sub-module com_divider (parameter WIDTH):
  - inputs: start, dividend, divisor
  - outputs: quotient, done, busy
  - unsigned, restoring; same clock and reset as the parent.

## Test plan
- T0 at (100,50) and (102,54), 8 pixels each (16 total), tabulate → x_out[0]=101, y_out[0]=52, present_out=4'b0001, valid_out after 1+4+64+1=70 cycles.
- T0 with 15 pixels, T2 with 16 pixels at (640,360) → present_out=4'b0100; x_out[0] holds its prior value; x_out[2]=640, y_out[2]=360.
- Truncation: T1 with sums x=1001, y=999 over count 16 → x_out[1]=62, y_out[1]=62.
- Second tabulate_in 10 cycles after the first → drop_out pulse, first pass completes with correct values; the following frame starts from cleared accumulators.
- All 4 targets fill a full 1280×720 frame → each centroid = (639,359), valid_out at 262 cycles, no cnt saturation.
- rst_in low for 1 cycle during DIVY → outputs are 0 immediately, no valid_out, next clean frame tabulates correctly.
